// File: rtl/bshifter_seq.sv
// Iterative shifter/rotator: moves an operand up to STEP positions per clock
// until the requested amount is reached, with valid/ready on both sides.
module bshifter_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_val,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_o,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; out_valid and its payload hold until out_ready is seen.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHW-1:0]     rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               o_q, o_d;

  logic [SHW-1:0]     k;
  logic [SHW-1:0]     lsl_idx;
  logic [SHW-1:0]     lsr_idx;
  logic [WIDTH-1:0]   shifted;
  logic               bit_out;

  function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] v,
                                                  input logic [1:0] m,
                                                  input logic f,
                                                  input logic [SHW-1:0] amt);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    case (m)
      M_LSL:   r = (v << amt) | (f ? ~(ones << amt) : '0);
      M_LSR:   r = (v >> amt) | (f ? ~(ones >> amt) : '0);
      M_ASR:   r = WIDTH'($signed(v) >>> amt);
      default: r = (v << amt) | (v >> (WIDTH - int'(amt)));
    endcase
    return r;
  endfunction

  always_comb begin
    k       = (rem_q < STEP_W) ? rem_q : STEP_W;
    // WIDTH is a power of two, so 0-k wraps to WIDTH-k within SHW bits.
    lsl_idx = SHW'(0) - k;
    lsr_idx = k - SHW'(1);
    shifted = step_shift(work_q, mode_q, fill_q, k);
    bit_out = (mode_q == M_LSL) ? work_q[lsl_idx] : work_q[lsr_idx];
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    res_d   = res_q;
    o_d     = o_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d = in_val;
          rem_d  = in_amt;
          mode_d = in_mode;
          fill_d = in_i;
          if (in_amt == '0) begin
            res_d   = in_val;
            o_d     = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) begin
          res_d   = shifted;
          o_d     = (mode_q == M_ROL) ? shifted[0] : bit_out;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      fill_q  <= 1'b0;
      res_q   <= '0;
      o_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      o_q     <= o_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_res   = res_q;
  assign out_o     = o_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bshifter_seq.sv
// Bench for bshifter_seq: directed vectors, randomized ops against a bitwise
// reference model, output hold under back-pressure, and reset mid-shift.
module tb_bshifter_seq;
  localparam int W   = 16;
  localparam int S   = 4;
  localparam int SHW = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_val;
  logic [SHW-1:0] in_amt;
  logic [1:0]     in_mode;
  logic           in_i;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_res;
  logic           out_o;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_cmp;
  int n_err;
  logic [W-1:0] exp_q[$];

  bshifter_seq #(.WIDTH(W), .STEP(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_amt(in_amt), .in_mode(in_mode), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_o(out_o), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each result bit picks its source position directly.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] v, input int amt,
                                           input logic [1:0] m, input logic f);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      case (m)
        2'b00:   r[b] = (b >= amt) ? v[b-amt] : f;
        2'b01:   r[b] = (b + amt < W) ? v[b+amt] : f;
        2'b10:   r[b] = (b + amt < W) ? v[b+amt] : v[W-1];
        default: r[b] = v[(b - amt + W) % W];
      endcase
    end
    return r;
  endfunction

  function automatic logic ref_o(input logic [W-1:0] v, input int amt,
                                 input logic [1:0] m, input logic [W-1:0] r);
    if (amt == 0) return 1'b0;
    case (m)
      2'b00:   return v[W-amt];
      2'b11:   return r[0];
      default: return v[amt-1];
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] v, input int amt, input logic [1:0] m,
                        input logic f, input int hold, input string tag);
    logic [W-1:0] e_res;
    logic         e_o;
    int           e_lat;
    int           lat;
    e_res = ref_res(v, amt, m, f);
    e_o   = ref_o(v, amt, m, e_res);
    e_lat = 1 + (amt + S - 1) / S;
    exp_q.push_back(e_res);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready_idle got=%b exp=1", tag, in_ready);
    end
    in_valid = 1'b1; in_val = v; in_amt = SHW'(amt); in_mode = m; in_i = f;
    @(posedge clk); #1;
    in_valid = 1'b0; in_val = W'($urandom); in_amt = SHW'($urandom); in_i = 1'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL %s shift_flags busy=%b in_ready=%b exp 1/0", tag, busy, in_ready);
      end
      @(posedge clk); #1;
      lat++;
    end
    e_res = exp_q.pop_front();
    n_cmp++;
    if (lat !== e_lat) begin
      n_err++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, e_lat);
    end
    n_cmp++;
    if (out_res !== e_res) begin
      n_err++; $display("FAIL %s out_res got=%h exp=%h", tag, out_res, e_res);
    end
    n_cmp++;
    if (out_o !== e_o) begin
      n_err++; $display("FAIL %s out_o got=%b exp=%b", tag, out_o, e_o);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_val = W'($urandom); in_amt = SHW'($urandom); in_mode = 2'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          out_res !== e_res || out_o !== e_o) begin
        n_err++;
        $display("FAIL %s hold valid=%b in_ready=%b busy=%b res=%h o=%b exp 1/0/1/%h/%b",
                 tag, out_valid, in_ready, busy, out_res, out_o, e_res, e_o);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_res !== e_res) begin
      n_err++;
      $display("FAIL %s after_handshake valid=%b busy=%b in_ready=%b res=%h exp 0/0/1/%h",
               tag, out_valid, busy, in_ready, out_res, e_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_val = '0; in_amt = '0; in_mode = '0; in_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_res !== '0 || out_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs valid=%b busy=%b res=%h o=%b exp all 0",
               out_valid, busy, out_res, out_o);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(16'h0001, 5,  2'b00, 1'b0, 0, "lsl_5");
    run_op(16'h8001, 1,  2'b01, 1'b1, 0, "lsr_1_fill1");
    run_op(16'h8000, 15, 2'b10, 1'b0, 1, "asr_15");
    run_op(16'h1234, 4,  2'b11, 1'b0, 0, "rol_4");
    run_op(16'hBEEF, 0,  2'b00, 1'b1, 3, "amt0_hold");
    run_op(16'hA5A5, 15, 2'b00, 1'b1, 0, "lsl_15_fill1");
    run_op(16'h7FFF, 8,  2'b10, 1'b1, 0, "asr_pos");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_op(W'($urandom), int'($urandom_range(0, W-1)), 2'($urandom_range(0, 3)),
             1'($urandom), int'($urandom_range(0, 2)), "random");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      run_op(W'($urandom), n * 2, 2'(n % 4), 1'(n % 2), 0, "b2b");
  endtask

  task automatic test_reset_mid_shift();
    run_op(16'h0F0F, 3, 2'b11, 1'b0, 0, "pre_reset");
    @(negedge clk);
    in_valid = 1'b1; in_val = 16'h1234; in_amt = 4'd15; in_mode = 2'b00; in_i = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_o !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midshift_reset valid=%b res=%h o=%b busy=%b exp 0/0000/0/0",
               out_valid, out_res, out_o, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midshift_in_ready got=%b exp=1", in_ready);
    end
    run_op(16'h00FF, 8, 2'b00, 1'b0, 0, "post_reset_lsl8");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
